// File: rtl/vga_frame_scheduler_pkg.sv
// Shared definitions for the VGA frame scheduler: FSM state encoding,
// default geometry and requester count, and the coordinate clamp helper.
package vga_frame_scheduler_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int COORD_W_DEF = 10;
    localparam int X_MAX_DEF   = 639;
    localparam int Y_MAX_DEF   = 479;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARB    = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Limit a coordinate to the largest legal screen position.
    function automatic logic [31:0] clamp_coord(input logic [31:0] v, input logic [31:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/vga_frame_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the priority pointer,
// pointer advances past the winner and holds when nothing is granted.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Pick the first requester at or after the pointer, wrapping to 0.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
        logic found;
        int   win;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        win   = 0;
        if (en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i >= int'(ptr_q))) begin
                    found = 1'b1;
                    win   = i;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i]) begin
                    found = 1'b1;
                    win   = i;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (found && (win == i)) begin
                    gnt[i] = 1'b1;
                end
            end
            if (found) begin
                ptr_d = (win == NUM_REQ - 1) ? '0 : PTR_W'(win + 1);
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vga_frame_scheduler.sv
// VGA frame scheduler: position updates from several requesters are
// accepted only during vertical blanking into a shadow copy, and the whole
// shadow is published to the renderer in one cycle when blanking ends.
module vga_frame_scheduler
    import vga_frame_scheduler_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int Y_MAX   = Y_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       blank_active,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COORD_W-1:0] wr_x,
    input  logic [NUM_REQ*COORD_W-1:0] wr_y,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ*COORD_W-1:0] obj_x,
    output logic [NUM_REQ*COORD_W-1:0] obj_y,
    output logic                       commit,
    output logic [7:0]                 dropped_cnt
);

    state_e state_q;
    state_e state_d;

    logic [COORD_W-1:0] shadow_x_q [NUM_REQ];
    logic [COORD_W-1:0] shadow_y_q [NUM_REQ];
    logic [COORD_W-1:0] shadow_x_d [NUM_REQ];
    logic [COORD_W-1:0] shadow_y_d [NUM_REQ];
    logic [COORD_W-1:0] obj_x_q    [NUM_REQ];
    logic [COORD_W-1:0] obj_y_q    [NUM_REQ];
    logic [COORD_W-1:0] obj_x_d    [NUM_REQ];
    logic [COORD_W-1:0] obj_y_d    [NUM_REQ];

    logic       commit_q;
    logic       commit_d;
    logic [7:0] dropped_q;
    logic [7:0] dropped_d;

    logic arb_en;
    logic enter_commit;

    // Grants are only issued while the window is open and blanking persists.
    assign arb_en       = (state_q == ST_ARB) && blank_active;
    assign enter_commit = (state_q == ST_ARB) && !blank_active;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (req),
        .gnt (gnt)
    );

    // Window sequencing: wait for blanking, arbitrate through it, publish once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (blank_active)  state_d = ST_ARB;
            ST_ARB:    if (!blank_active) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Granted requester overwrites its shadow slot with clamped coordinates.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            shadow_x_d[i] = shadow_x_q[i];
            shadow_y_d[i] = shadow_y_q[i];
            if (gnt[i]) begin
                shadow_x_d[i] = COORD_W'(clamp_coord(32'(wr_x[i*COORD_W +: COORD_W]), 32'(X_MAX)));
                shadow_y_d[i] = COORD_W'(clamp_coord(32'(wr_y[i*COORD_W +: COORD_W]), 32'(Y_MAX)));
            end
        end
    end

    // Publish the shadow, raise commit and count leftover requests at window end.
    always_comb begin
        int pending;
        int sum;
        pending  = 0;
        sum      = 0;
        commit_d = enter_commit;
        for (int i = 0; i < NUM_REQ; i++) begin
            obj_x_d[i] = enter_commit ? shadow_x_q[i] : obj_x_q[i];
            obj_y_d[i] = enter_commit ? shadow_y_q[i] : obj_y_q[i];
            if (req[i]) begin
                pending = pending + 1;
            end
        end
        sum       = int'(dropped_q) + pending;
        dropped_d = dropped_q;
        if (enter_commit) begin
            dropped_d = (sum > 255) ? 8'd255 : 8'(sum);
        end
    end

    // Output packing of the committed positions.
    always_comb begin
        obj_x = '0;
        obj_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            obj_x[i*COORD_W +: COORD_W] = obj_x_q[i];
            obj_y[i*COORD_W +: COORD_W] = obj_y_q[i];
        end
    end

    assign commit      = commit_q;
    assign dropped_cnt = dropped_q;

    // FSM state, shadow, published positions, commit pulse and drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            commit_q  <= 1'b0;
            dropped_q <= '0;
            // NOTE: the shadow is an explicitly reset register array, not RAM, so a mid-window reset discards partial writes.
            for (int i = 0; i < NUM_REQ; i++) begin
                shadow_x_q[i] <= '0;
                shadow_y_q[i] <= '0;
                obj_x_q[i]    <= '0;
                obj_y_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            commit_q  <= commit_d;
            dropped_q <= dropped_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                shadow_x_q[i] <= shadow_x_d[i];
                shadow_y_q[i] <= shadow_y_d[i];
                obj_x_q[i]    <= obj_x_d[i];
                obj_y_q[i]    <= obj_y_d[i];
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Self-checking bench for vga_frame_scheduler: directed blanking-window
// scenarios plus randomized requester traffic, compared cycle by cycle
// against a behavioural model of the scheduling rules.
module tb_vga_frame_scheduler;

    localparam int N  = 3;
    localparam int W  = 10;
    localparam int XM = 639;
    localparam int YM = 479;

    localparam int M_IDLE   = 0;
    localparam int M_ARB    = 1;
    localparam int M_COMMIT = 2;

    logic           clk;
    logic           rst;
    logic           blank_active;
    logic [N-1:0]   req;
    logic [N*W-1:0] wr_x;
    logic [N*W-1:0] wr_y;
    logic [N-1:0]   gnt;
    logic [N*W-1:0] obj_x;
    logic [N*W-1:0] obj_y;
    logic           commit;
    logic [7:0]     dropped_cnt;

    vga_frame_scheduler #(
        .NUM_REQ (N),
        .COORD_W (W),
        .X_MAX   (XM),
        .Y_MAX   (YM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .blank_active (blank_active),
        .req          (req),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .gnt          (gnt),
        .obj_x        (obj_x),
        .obj_y        (obj_y),
        .commit       (commit),
        .dropped_cnt  (dropped_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Requester-side data and the reference model's view of the block.
    int rq_x [N];
    int rq_y [N];
    int m_state;
    int m_ptr;
    int m_sx [N];
    int m_sy [N];
    int m_ox [N];
    int m_oy [N];
    int m_drop;
    bit m_commit;
    logic [N-1:0] seen_gnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_state  = M_IDLE;
        m_ptr    = 0;
        m_drop   = 0;
        m_commit = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_ox[i] = 0; m_oy[i] = 0;
        end
    endtask

    task automatic check_outputs();
        check("commit", {31'b0, commit}, {31'b0, m_commit});
        for (int i = 0; i < N; i++) begin
            check($sformatf("obj_x%0d", i), 32'(obj_x[i*W +: W]), m_ox[i]);
            check($sformatf("obj_y%0d", i), 32'(obj_y[i*W +: W]), m_oy[i]);
        end
        check("dropped_cnt", 32'(dropped_cnt), m_drop);
    endtask

    // One clock cycle: drive inputs, check gnt, advance the model, check outputs.
    task automatic step(input bit b, input bit rnd);
        logic [N-1:0] eg;
        int win;
        int pending;
        @(negedge clk);
        blank_active = b;
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i]  = 1'b1;
                    rq_x[i] = int'($urandom_range(0, 1023));
                    rq_y[i] = int'($urandom_range(0, 1023));
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            wr_x[i*W +: W] = W'(rq_x[i]);
            wr_y[i*W +: W] = W'(rq_y[i]);
        end
        #1;
        eg  = '0;
        win = -1;
        if (m_state == M_ARB && b) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win >= 0) eg[win] = 1'b1;
        end
        seen_gnt = gnt;
        check("gnt", 32'(gnt), 32'(eg));

        @(posedge clk);
        #1;
        pending = 0;
        for (int i = 0; i < N; i++) if (req[i]) pending++;
        m_commit = 1'b0;
        if (win >= 0) begin
            m_sx[win] = clampv(rq_x[win], XM);
            m_sy[win] = clampv(rq_y[win], YM);
            m_ptr     = (win + 1) % N;
            req[win]  = 1'b0;
        end
        if (m_state == M_IDLE) begin
            if (b) m_state = M_ARB;
        end else if (m_state == M_ARB) begin
            if (!b) begin
                m_state  = M_COMMIT;
                m_commit = 1'b1;
                m_drop   = (m_drop + pending > 255) ? 255 : m_drop + pending;
                for (int i = 0; i < N; i++) begin
                    m_ox[i] = m_sx[i];
                    m_oy[i] = m_sy[i];
                end
            end
        end else begin
            m_state = M_IDLE;
        end
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_objx"}, 32'(obj_x), 0);
        check({tag, "_objy"}, 32'(obj_y), 0);
        check({tag, "_commit"}, {31'b0, commit}, 0);
        check({tag, "_dropped"}, 32'(dropped_cnt), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        blank_active = 1'b0;
        req          = '0;
        wr_x         = '0;
        wr_y         = '0;
        seen_gnt     = '0;
        for (int i = 0; i < N; i++) begin
            rq_x[i] = 0; rq_y[i] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Round-robin across a full window, then a second window with two requesters.
        for (int i = 0; i < N; i++) begin
            rq_x[i] = 100 + 10 * i; rq_y[i] = 200 + 20 * i;
        end
        req = 3'b111;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0); check("rr_w1_g0", 32'(seen_gnt), 32'b001);
        step(1'b1, 1'b0); check("rr_w1_g1", 32'(seen_gnt), 32'b010);
        step(1'b1, 1'b0); check("rr_w1_g2", 32'(seen_gnt), 32'b100);
        step(1'b0, 1'b0); check("rr_w1_commit", {31'b0, commit}, 1);
        step(1'b0, 1'b0);
        rq_x[0] = 5; rq_y[0] = 6; rq_x[1] = 7; rq_y[1] = 8;
        req = 3'b011;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0); check("rr_w2_g0", 32'(seen_gnt), 32'b001);
        step(1'b1, 1'b0); check("rr_w2_g1", 32'(seen_gnt), 32'b010);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Single ball-slot update over a five-cycle blank.
        rq_x[0] = 300; rq_y[0] = 460;
        req = 3'b001;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0); check("single_first_arb_gnt", 32'(seen_gnt), 32'b001);
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("single_commit", {31'b0, commit}, 1);
        check("single_x0", 32'(obj_x[0 +: W]), 300);
        check("single_y0", 32'(obj_y[0 +: W]), 460);
        step(1'b0, 1'b0); check("single_commit_drop", {31'b0, commit}, 0);

        // Out-of-range coordinates are clamped to the screen edge.
        rq_x[1] = 1000; rq_y[1] = 500;
        req = 3'b010;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("clamp_x1", 32'(obj_x[W +: W]), XM);
        check("clamp_y1", 32'(obj_y[W +: W]), YM);
        step(1'b0, 1'b0);

        // Requests during active video wait; a one-grant window leaves one pending.
        req = 3'b110;
        repeat (3) begin
            step(1'b0, 1'b0); check("active_no_gnt", 32'(seen_gnt), 0);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("short_blank_dropped", 32'(dropped_cnt), 1);
        check("short_blank_left", 32'($countones(req)), 1);
        step(1'b0, 1'b0);

        // Randomized traffic with random active/blank lengths.
        for (int f = 0; f < 60; f++) begin
            repeat ($urandom_range(1, 4)) step(1'b0, 1'b1);
            repeat ($urandom_range(1, 6)) step(1'b1, 1'b1);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Reset in the middle of a window after two grants.
        req = 3'b111;
        for (int i = 0; i < N; i++) begin
            rq_x[i] = 50 + i; rq_y[i] = 60 + i;
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all_zero("midreset");
        repeat (2) begin
            @(posedge clk);
            #1;
            check("midreset_no_commit", {31'b0, commit}, 0);
        end
        @(negedge clk);
        blank_active = 1'b0;
        rst          = 1'b1;
        step(1'b0, 1'b0); check("post_reset_idle_gnt", 32'(seen_gnt), 0);
        step(1'b1, 1'b0); check("post_reset_enter_gnt", 32'(seen_gnt), 0);
        step(1'b1, 1'b0); check("post_reset_first_gnt", {31'b0, seen_gnt != 0}, 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Drop counter saturation: one unserved request every frame.
        req = 3'b100;
        for (int f = 0; f < 300; f++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end
        check("dropped_saturated", 32'(dropped_cnt), 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
